// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and the image DMA engine. One owner per cycle; the CPU has priority but may
// only take a bounded run of accesses while the DMA is waiting.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees ack high. ack high means the access happened in this cycle:
// read data is valid now, and a write lands at the closing clock edge. A
// requester that sees ack low simply keeps waiting; nothing is queued for it.
module dmem_arbiter #(
   parameter int          CPU_MAX_RUN = 8,
   parameter logic [31:0] MEM_DEPTH   = 32'd65536
) (
   input  logic        clk,
   input  logic        rst_n,
   // CPU MEM stage
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic [7:0]  cpu_rdata_b,
   // image DMA engine
   input  logic        dma_en,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [31:0] dma_rdata,
   output logic        dma_err,
   // DataMemory port
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_b,
   output logic [7:0]  mem_din,
   input  logic [31:0] mem_do,
   input  logic [7:0]  mem_dob
);

   localparam int RUN_W = (CPU_MAX_RUN > 1) ? $clog2(CPU_MAX_RUN) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CPU_MAX_RUN - 1);

   // Owner register: who is allowed to use the memory port this cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DMA  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [RUN_W-1:0] run_cnt;
   logic [RUN_W-1:0] run_cnt_nx;
   logic [RUN_W-1:0] run_eff;
   logic             dma_live;
   logic             dma_in_range;
   logic             force_dma;
   logic             dma_err_q;

   // A DMA request only competes when the engine is enabled.
   assign dma_live = dma_req & dma_en;

   // The last four bytes are excluded so the A+4 read never leaves the array.
   assign dma_in_range = (dma_addr < (MEM_DEPTH - 32'd4));

   // Read data is a pure pass-through; requesters qualify it with their ack.
   assign cpu_rdata   = mem_do;
   assign cpu_rdata_b = mem_dob;
   assign dma_rdata   = mem_do;
   assign dma_err     = dma_err_q;

   // State register: owner changes only at clock edges, reset forces IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Run length including the CPU access happening right now, saturating.
   always_comb begin
      run_eff = run_cnt;
      if (cpu_ack && (run_cnt != RUN_LAST)) begin
         run_eff = run_cnt + RUN_W'(1);
      end
   end

   // Next-state: CPU wins unless its run is used up while DMA waits.
   always_comb begin
      force_dma = (state == ST_CPU) & dma_live & (run_eff == RUN_LAST);
      state_nx  = ST_IDLE;
      if (cpu_req && !force_dma) begin
         state_nx = ST_CPU;
      end else if (dma_live) begin
         state_nx = ST_DMA;
      end
   end

   // Output decode: owner mux onto the memory port plus the owner's ack.
   always_comb begin
      cpu_ack = 1'b0;
      dma_ack = 1'b0;
      mem_we  = 1'b0;
      mem_a   = 32'd0;
      mem_din = 8'd0;
      case (state)
         ST_CPU: begin
            mem_a   = cpu_addr;
            mem_din = cpu_wdata;
            cpu_ack = cpu_req;
            mem_we  = cpu_req & cpu_we;
         end
         ST_DMA: begin
            mem_a   = dma_addr;
            mem_din = dma_wdata;
            dma_ack = dma_req;
            // an out-of-range DMA access retires but must never write
            mem_we  = dma_req & dma_we & dma_in_range;
         end
         default: begin
         end
      endcase
   end

   // Port B always tracks A+4; the carry out of bit 31 is dropped.
   assign mem_b = mem_a + 32'd4;

   // Run counter restarts whenever the CPU loses the port or DMA is served.
   always_comb begin
      run_cnt_nx = run_eff;
      if ((state_nx != ST_CPU) || dma_ack) begin
         run_cnt_nx = '0;
      end
   end

   // Run counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt_nx;
      end
   end

   // Sticky error flag for DMA accesses outside the implemented memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dma_err_q <= 1'b0;
      end else if (dma_ack && !dma_in_range) begin
         dma_err_q <= 1'b1;
      end
   end

   // Only one requester may ever be acknowledged in a cycle.
   a_one_ack : assert property (@(posedge clk) disable iff (!rst_n)
      !(cpu_ack && dma_ack));

   // A write strobe is only legal on an acknowledged access.
   a_we_acked : assert property (@(posedge clk) disable iff (!rst_n)
      mem_we |-> (cpu_ack || dma_ack));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, a small memory behind the port,
// and a per-cycle compare against a request-level arbitration model.
module tb_dmem_arbiter;

   localparam int          CPU_MAX_RUN = 8;
   localparam logic [31:0] MEM_DEPTH   = 32'd65536;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  wdata;
   } txn_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic [7:0]  cpu_rdata_b;
   logic        dma_en, dma_req, dma_we;
   logic [31:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic [31:0] dma_rdata;
   logic        dma_err;
   logic        mem_we;
   logic [31:0] mem_a, mem_b;
   logic [7:0]  mem_din;
   logic [31:0] mem_do;
   logic [7:0]  mem_dob;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_on = 1'b0;

   txn_t cpu_q[$];
   txn_t dma_q[$];
   int   ev_q[$];
   logic last_cpu_ack = 1'b0;
   logic last_dma_ack = 1'b0;

   // environment memory and the model's own view of it
   logic [7:0] mem    [256];
   logic [7:0] shadow [256];

   // model state
   int   m_owner  = 0;   // 0 nobody, 1 CPU, 2 DMA
   int   m_streak = 0;   // CPU accesses in a row
   logic m_err    = 1'b0;
   logic e_cpu_ack, e_dma_ack, e_we, e_rng;
   logic [31:0] e_a;
   logic [7:0]  e_din;

   dmem_arbiter #(.CPU_MAX_RUN(CPU_MAX_RUN), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rdata_b(cpu_rdata_b),
      .dma_en(dma_en), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_b(mem_b), .mem_din(mem_din),
      .mem_do(mem_do), .mem_dob(mem_dob)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // asynchronous-read memory behind the port (256 bytes, address wraps)
   always_comb begin
      logic [7:0] ia;
      logic [7:0] ib;
      ia = mem_a[7:0];
      ib = mem_b[7:0];
      mem_do  = {mem[ia + 8'd3], mem[ia + 8'd2], mem[ia + 8'd1], mem[ia]};
      mem_dob = mem[ib];
   end

   always @(posedge clk) begin
      if (mem_we) mem[mem_a[7:0]] <= mem_din;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sh_word(input logic [31:0] a);
      logic [7:0] i;
      i = a[7:0];
      return {shadow[i + 8'd3], shadow[i + 8'd2], shadow[i + 8'd1], shadow[i]};
   endfunction

   function automatic int cnt_ev(input int v);
      int n = 0;
      foreach (ev_q[i]) if (ev_q[i] == v) n++;
      return n;
   endfunction

   // compare process: model expectations vs DUT, once per cycle
   always @(negedge clk) begin
      logic [31:0] a4;
      last_cpu_ack = cpu_ack;
      last_dma_ack = dma_ack;
      e_cpu_ack = (m_owner == 1) && cpu_req;
      e_dma_ack = (m_owner == 2) && dma_req;
      e_rng     = (dma_addr < (MEM_DEPTH - 32'd4));
      e_a       = (m_owner == 1) ? cpu_addr  : (m_owner == 2) ? dma_addr  : 32'd0;
      e_din     = (m_owner == 1) ? cpu_wdata : (m_owner == 2) ? dma_wdata : 8'd0;
      e_we      = (e_cpu_ack && cpu_we) || (e_dma_ack && dma_we && e_rng);
      if (rst_n && chk_on) begin
         chk("cpu_ack", cpu_ack, e_cpu_ack);
         chk("dma_ack", dma_ack, e_dma_ack);
         chk("mem_we", mem_we, e_we);
         chk("mem_a", mem_a, e_a);
         chk("mem_b", mem_b, e_a + 32'd4);
         chk("mem_din", mem_din, e_din);
         chk("dma_err", dma_err, m_err);
         if (e_cpu_ack) begin
            a4 = cpu_addr + 32'd4;
            chk("cpu_rdata", cpu_rdata, sh_word(cpu_addr));
            chk("cpu_rdata_b", cpu_rdata_b, shadow[a4[7:0]]);
         end
         if (e_dma_ack && e_rng) chk("dma_rdata", dma_rdata, sh_word(dma_addr));
         ev_q.push_back(int'(cpu_ack) + 2 * int'(dma_ack));
      end
   end

   // model update: who owns the port next, writes, sticky error
   always @(posedge clk) begin
      logic d;
      if (!rst_n) begin
         m_owner  = 0;
         m_streak = 0;
         m_err    = 1'b0;
      end else begin
         if (e_we) shadow[e_a[7:0]] = e_din;
         if (e_dma_ack && !e_rng) m_err = 1'b1;
         if (e_cpu_ack) m_streak++;
         d = dma_req && dma_en;
         if (cpu_req && !(m_owner == 1 && d && m_streak >= CPU_MAX_RUN - 1)) m_owner = 1;
         else if (d) m_owner = 2;
         else m_owner = 0;
         if (m_owner != 1) m_streak = 0;
      end
   end

   // driver tasks
   task automatic drive();
      if (cpu_q.size() != 0) begin
         cpu_req = 1'b1; cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
      end else begin
         cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 8'd0;
      end
      if (dma_q.size() != 0) begin
         dma_req = 1'b1; dma_we = dma_q[0].we; dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].wdata;
      end else begin
         dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 8'd0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (last_cpu_ack && cpu_q.size() != 0) void'(cpu_q.pop_front());
      if (last_dma_ack && dma_q.size() != 0) void'(dma_q.pop_front());
      drive();
   endtask

   task automatic begin_test();
      ev_q.delete();
      drive();
   endtask

   task automatic push_cpu(input logic we, input logic [31:0] a, input logic [7:0] d);
      cpu_q.push_back('{we: we, addr: a, wdata: d});
   endtask

   task automatic push_dma(input logic we, input logic [31:0] a, input logic [7:0] d);
      dma_q.push_back('{we: we, addr: a, wdata: d});
   endtask

   initial begin
      int run;
      logic pushed;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'(i) ^ 8'h5C;
         shadow[i] = 8'(i) ^ 8'h5C;
      end
      rst_n = 1'b0;
      dma_en = 1'b1;
      drive();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_dma_ack", dma_ack, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_b", mem_b, 32'h4);
      chk("rst_mem_din", mem_din, 8'h0);
      chk("rst_dma_err", dma_err, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_on = 1'b1;
      repeat (2) step();

      // CPU read alone: grant one cycle after the request
      push_cpu(1'b0, 32'h10, 8'h0);
      begin_test();
      step();
      @(negedge clk);
      chk("t1_cpu_ack", cpu_ack, 1'b1);
      chk("t1_mem_a", mem_a, 32'h10);
      chk("t1_mem_b", mem_b, 32'h14);
      chk("t1_mem_we", mem_we, 1'b0);
      repeat (3) step();
      chk("t1_no_ack_cyc0", ev_q[0], 0);

      // CPU run limit: 12 CPU reads against one waiting DMA read
      for (int i = 0; i < 12; i++) push_cpu(1'b0, 32'h40 + 32'(4 * i), 8'h0);
      push_dma(1'b0, 32'h80, 8'h0);
      begin_test();
      repeat (18) step();
      run = 0;
      for (int i = 1; i < ev_q.size() && ev_q[i] == 1; i++) run++;
      chk("t2_cpu_run", run, 7);
      chk("t2_dma_slot", ev_q[8], 2);
      chk("t2_cpu_resume", ev_q[9], 1);
      chk("t2_cpu_total", cnt_ev(1), 12);
      chk("t2_dma_total", cnt_ev(2), 1);
      chk("t2_drained", cpu_q.size() + dma_q.size(), 0);

      // DMA streaming writes, CPU cuts in during access 5
      for (int i = 0; i < 16; i++) push_dma(1'b1, 32'h100 + 32'(i), 8'(i));
      begin_test();
      pushed = 1'b0;
      repeat (30) begin
         step();
         if (!pushed && dma_q.size() == 11) begin
            push_cpu(1'b0, 32'h100, 8'h0);
            drive();
            pushed = 1'b1;
         end
      end
      chk("t3_dma_acc5", ev_q[6], 2);
      chk("t3_cpu_next", ev_q[7], 1);
      chk("t3_bubble", ev_q[8], 0);
      chk("t3_dma_resume", ev_q[9], 2);
      chk("t3_dma_total", cnt_ev(2), 16);
      chk("t3_drained", cpu_q.size() + dma_q.size(), 0);

      // read back part of the streamed block
      push_cpu(1'b0, 32'h104, 8'h0);
      begin_test();
      step();
      @(negedge clk);
      chk("t3b_ack", cpu_ack, 1'b1);
      chk("t3b_word", cpu_rdata, 32'h07060504);
      chk("t3b_byte", cpu_rdata_b, 8'h08);
      repeat (3) step();

      // out-of-range DMA write
      push_dma(1'b1, 32'hFFFF_FFFE, 8'hAB);
      begin_test();
      step();
      @(negedge clk);
      chk("t4_dma_ack", dma_ack, 1'b1);
      chk("t4_mem_we", mem_we, 1'b0);
      chk("t4_mem_b", mem_b, 32'h0000_0002);
      step();
      @(negedge clk);
      chk("t4_err_set", dma_err, 1'b1);
      repeat (3) step();
      chk("t4_byte_kept", mem[254], 8'hA2);

      // DMA disabled: requests ignored, CPU unaffected
      dma_en = 1'b0;
      push_dma(1'b0, 32'h200, 8'h0);
      for (int i = 0; i < 5; i++) push_cpu(1'b0, 32'h20 + 32'(i), 8'h0);
      begin_test();
      repeat (20) step();
      chk("t6_no_dma_ack", cnt_ev(2), 0);
      chk("t6_cpu_acks", cnt_ev(1), 5);
      chk("t6_err_sticky", dma_err, 1'b1);
      dma_q.delete();
      drive();
      dma_en = 1'b1;
      repeat (2) step();

      // reset asserted during a CPU write
      push_cpu(1'b1, 32'h30, 8'h77);
      begin_test();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_mem_we", mem_we, 1'b0);
      chk("t5_cpu_ack", cpu_ack, 1'b0);
      chk("t5_mem_a", mem_a, 32'h0);
      chk("t5_mem_b", mem_b, 32'h4);
      chk("t5_err_clr", dma_err, 1'b0);
      cpu_q.delete();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) step();
      chk("t5_byte_kept", mem[8'h30], 8'h6C);

      // after reset the arbiter starts again from idle
      push_cpu(1'b0, 32'h30, 8'h0);
      begin_test();
      repeat (3) step();
      chk("t5b_idle_cyc0", ev_q[0], 0);
      chk("t5b_ack_cyc1", ev_q[1], 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
